con_status_responder: RTL
=========================

// Module: con_status_responder
// PURPOSE
//  Parametrised successor of the config-link reconfig ack responder. Watches the byte-wide con_din
//  command stream for frames whose first two bytes match a programmable ID, captures the header,
//  waits a programmable gap, then transmits an echo reply followed by pad, marker and status bytes.
//  Frames that arrive while a reply is pending are dropped and counted; short frames are ignored.
// PARAMETERS
//  HDR_BYTES    8      header bytes captured and echoed (>=2)
//  PAD_BYTES    4      pad bytes after echo (>=0)
//  PAD_VALUE    8'hFF  pad byte value
//  MARKER       8'hAA  marker byte preceding status
//  STAT_BYTES   2      status bytes sent, status_vec[7:0] first (>=1)
//  MATCH_B0     8'h04  required frame byte 0
//  MATCH_B1     8'h32  required frame byte 1
//  WAIT_CYCLES  100    idle gap between frame end and first reply byte (>=1)
//  CNT_W        11     frame byte counter width (saturating)
// PORTS
//  clk         in   1              system clock; single clock domain
//  rst         in   1              synchronous, active-high reset
//  con_din     in   8              command byte stream
//  con_din_en  in   1              byte valid; one frame = one contiguous high run
//  status_vec  in   8*STAT_BYTES   status to report; byte k = status_vec[8k+7:8k]
//  con_dout    out  8              reply byte; 0 when con_dout_en low
//  con_dout_en out  1              reply byte valid
//  resp_busy   out  1              high in WAIT or SEND
//  drop_cnt    out  8              frames dropped while busy; saturates at 255
// BEHAVIOUR
//  - Reset: con_dout=0, con_dout_en=0, resp_busy=0, drop_cnt=0, state=IDLE, header regs=0.
//  - Frame capture: byte counter cleared when con_din_en low, increments per valid byte,
//    saturates at 2^CNT_W-1 (no wrap). Bytes 0..HDR_BYTES-1 stored into hdr[i] only if frame accepted.
//  - Accept: frame is accepted iff it starts (rising con_din_en) while state==IDLE. A frame started
//    while busy is dropped entirely even if the block goes IDLE mid-frame; drop_cnt += 1 at its start.
//  - Qualify: at frame end (first edge sampling con_din_en=0, call it E0), accepted frame with
//    byte0==MATCH_B0, byte1==MATCH_B1 and length>=HDR_BYTES -> IDLE->WAIT. Otherwise stay IDLE.
//  - WAIT: wait_cnt counts from 0; at the edge where wait_cnt==WAIT_CYCLES-1 -> SEND and snapshot
//    status_vec into stat regs. con_dout_en first high after edge E0+WAIT_CYCLES+1.
//  - SEND: outputs registered; send_cnt 0..RLEN-1, RLEN=HDR_BYTES+PAD_BYTES+1+STAT_BYTES.
//    Order: hdr[0..HDR_BYTES-1], PAD_VALUE x PAD_BYTES, MARKER, stat byte 0..STAT_BYTES-1.
//    con_dout_en high for exactly RLEN consecutive cycles; last byte -> IDLE, outputs 0 next cycle.
//  - Status change during SEND has no effect (snapshot). Input activity during WAIT/SEND never
//    alters header regs or the reply.
//  - Simultaneous: frame end and a new frame start on adjacent cycles handled independently;
//    frame starting on the same edge SEND ends is dropped (state not yet IDLE at its start).
//  - rst mid-WAIT/SEND: abort, outputs 0 on the following cycle, no resumption.
// STRUCTURE
//  - con_resp_defs.vh: state encodings (IDLE=0, WAIT=1, SEND=2), default ID/marker/pad constants.
//  - Sub-module con_frame_capture: byte counter, accept/drop flag, header regs, ID match,
//    emits frame_ok pulse at E0 and drop pulse. Top holds FSM, wait/send counters, output mux.
// TESTING
//  1 Frame 04 32 01..06, status_vec=16'h035A -> after 100-cycle gap, 15 contiguous bytes:
//    04 32 01 02 03 04 05 06 FF FF FF FF AA 5A 03; resp_busy high WAIT..SEND.
//  2 Frame 04 33 01..06 -> no con_dout_en for 500 cycles; drop_cnt stays 0.
//  3 Frame 04 32 01 02 03 (5 bytes) -> no reply.
//  4 Valid frame A, then frame 04 32 AA.. during WAIT -> drop_cnt=1, reply echoes A's header only.
//  5 rst asserted at 5th reply byte -> con_dout_en=0, con_dout=0 next cycle; no further bytes.
//  6 status_vec changes from 16'h035A to 16'hFFFF mid-SEND -> reply still ends 5A 03;
//    plus 300 dropped frames -> drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/con_status_responder_pkg.sv
// ---------------------------------------------------------------------------
// con_status_responder_pkg
// Shared definitions for the status responder: FSM state encoding, default
// frame ID / pad / marker constants and a helper that computes reply length.
// ---------------------------------------------------------------------------
package con_status_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic [7:0] DEF_MATCH_B0  = 8'h04;
  localparam logic [7:0] DEF_MATCH_B1  = 8'h32;
  localparam logic [7:0] DEF_PAD_VALUE = 8'hFF;
  localparam logic [7:0] DEF_MARKER    = 8'hAA;

  // Reply = echoed header, pad run, one marker byte, status bytes.
  function automatic int reply_len(input int hdr_bytes, input int pad_bytes, input int stat_bytes);
    return hdr_bytes + pad_bytes + 1 + stat_bytes;
  endfunction

endpackage

// File: rtl/con_status_responder_if.sv
// ---------------------------------------------------------------------------
// con_status_responder_if
// Byte-wide command/reply link between a host and the status responder.
//   con_din / con_din_en   : command byte stream, host -> responder
//   con_dout / con_dout_en : reply byte stream, responder -> host
// Modports: master = host side, slave = responder side.
// ---------------------------------------------------------------------------
interface con_status_responder_if;
  logic [7:0] con_din;
  logic       con_din_en;
  logic [7:0] con_dout;
  logic       con_dout_en;

  modport master (output con_din, output con_din_en, input con_dout, input con_dout_en);
  modport slave  (input con_din, input con_din_en, output con_dout, output con_dout_en);
endinterface

// File: rtl/con_status_responder_frame_capture.sv
// ---------------------------------------------------------------------------
// con_status_responder_frame_capture
// Tracks frames on the command stream (one frame = one contiguous din_en run),
// decides at frame start whether the frame is accepted, stores the header of
// accepted frames and qualifies them at frame end.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   din_i         : command byte
//   din_en_i      : command byte valid
//   idle_i        : responder FSM is IDLE (frame may be accepted)
//   frame_ok_o    : pulse on the first edge sampling din_en low after an
//                   accepted frame with matching ID and full header
//   drop_o        : pulse on the start edge of a frame that is dropped
//   hdr_o         : captured header bytes, hdr_o[0] = first frame byte
// ---------------------------------------------------------------------------
module con_status_responder_frame_capture
  import con_status_responder_pkg::*;
#(
  parameter int         HDR_BYTES = 8,
  parameter logic [7:0] MATCH_B0  = DEF_MATCH_B0,
  parameter logic [7:0] MATCH_B1  = DEF_MATCH_B1,
  parameter int         CNT_W     = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                din_i,
  input  logic                      din_en_i,
  input  logic                      idle_i,
  output logic                      frame_ok_o,
  output logic                      drop_o,
  output logic [HDR_BYTES-1:0][7:0] hdr_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                      en_prev_q;
  logic                      acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [HDR_BYTES-1:0][7:0] hdr_q, hdr_d;
  logic                      start_s;
  logic                      end_s;

  // Frame edge detection, accept decision, byte counter and header capture.
  always_comb begin
    start_s = din_en_i & ~en_prev_q;
    end_s   = ~din_en_i & en_prev_q;

    // Acceptance is decided once, at the start edge, and held for the frame.
    if (start_s) begin
      acc_d = idle_i;
    end else begin
      acc_d = acc_q;
    end

    // cnt_q is the index of the byte currently on din_i; saturates, never wraps.
    if (!din_en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    hdr_d = hdr_q;
    for (int i = 0; i < HDR_BYTES; i++) begin
      hdr_d[i] = (din_en_i && acc_d && (cnt_q == CNT_W'(i))) ? din_i : hdr_q[i];
    end

    // At frame end cnt_q still holds the (saturated) frame length.
    frame_ok_o = end_s && acc_q && (hdr_q[0] == MATCH_B0) && (hdr_q[1] == MATCH_B1)
                 && (cnt_q >= CNT_W'(HDR_BYTES));
    drop_o     = start_s && !idle_i;
  end

  // Capture state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_prev_q <= 1'b0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      hdr_q     <= '0;
    end else begin
      en_prev_q <= din_en_i;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
    end
  end

  assign hdr_o = hdr_q;

endmodule

// File: rtl/con_status_responder.sv
// ---------------------------------------------------------------------------
// con_status_responder
// Watches the command stream for frames starting with a programmable ID,
// waits WAIT_CYCLES after frame end, then sends: echoed header, pad bytes,
// marker, snapshot of status_vec (low byte first). Frames starting while a
// reply is pending are dropped and counted.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : slave side of the command/reply link
//   status_vec  : status to report, byte k = status_vec[8k+7:8k]
//   resp_busy   : high while a reply is pending (WAIT or SEND)
//   drop_cnt    : frames dropped while busy, saturates at 255
// ---------------------------------------------------------------------------
module con_status_responder
  import con_status_responder_pkg::*;
#(
  parameter int         HDR_BYTES   = 8,
  parameter int         PAD_BYTES   = 4,
  parameter logic [7:0] PAD_VALUE   = DEF_PAD_VALUE,
  parameter logic [7:0] MARKER      = DEF_MARKER,
  parameter int         STAT_BYTES  = 2,
  parameter logic [7:0] MATCH_B0    = DEF_MATCH_B0,
  parameter logic [7:0] MATCH_B1    = DEF_MATCH_B1,
  parameter int         WAIT_CYCLES = 100,
  parameter int         CNT_W       = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  con_status_responder_if.slave   bus,
  input  logic [8*STAT_BYTES-1:0] status_vec,
  output logic                    resp_busy,
  output logic [7:0]              drop_cnt
);

  localparam int RLEN   = reply_len(HDR_BYTES, PAD_BYTES, STAT_BYTES);
  localparam int SCNT_W = $clog2(RLEN);
  localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);

  state_e                    state_q, state_d;
  logic [WCNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [SCNT_W-1:0]         send_cnt_q, send_cnt_d;
  logic [8*STAT_BYTES-1:0]   stat_q, stat_d;
  logic [7:0]                dout_q, dout_d;
  logic                      dout_en_q, dout_en_d;
  logic                      busy_q, busy_d;
  logic [7:0]                drop_q, drop_d;
  logic [7:0]                reply_byte_s;
  logic                      frame_ok_s;
  logic                      drop_s;
  logic [HDR_BYTES-1:0][7:0] hdr_s;

  con_status_responder_frame_capture #(
    .HDR_BYTES (HDR_BYTES),
    .MATCH_B0  (MATCH_B0),
    .MATCH_B1  (MATCH_B1),
    .CNT_W     (CNT_W)
  ) u_capture (
    .clk_i      (clk),
    .rst_i      (rst),
    .din_i      (bus.con_din),
    .din_en_i   (bus.con_din_en),
    .idle_i     (state_q == ST_IDLE),
    .frame_ok_o (frame_ok_s),
    .drop_o     (drop_s),
    .hdr_o      (hdr_s)
  );

  // State, counter and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      send_cnt_q <= '0;
      stat_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      send_cnt_q <= send_cnt_d;
      stat_q     <= stat_d;
    end
  end

  // Next-state logic; counters restart from zero whenever their state is left.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    send_cnt_d = '0;
    stat_d     = stat_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_ok_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
          state_d = ST_SEND;
          stat_d  = status_vec;   // snapshot: later status changes do not reach the reply
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_SEND: begin
        if (send_cnt_q == SCNT_W'(RLEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_SEND;
          send_cnt_d = send_cnt_q + SCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reply byte selection by position within the reply.
  always_comb begin
    reply_byte_s = 8'h00;
    for (int i = 0; i < HDR_BYTES; i++) begin
      reply_byte_s = (send_cnt_q == SCNT_W'(i)) ? hdr_s[i] : reply_byte_s;
    end
    for (int i = 0; i < PAD_BYTES; i++) begin
      reply_byte_s = (send_cnt_q == SCNT_W'(HDR_BYTES + i)) ? PAD_VALUE : reply_byte_s;
    end
    reply_byte_s = (send_cnt_q == SCNT_W'(HDR_BYTES + PAD_BYTES)) ? MARKER : reply_byte_s;
    for (int i = 0; i < STAT_BYTES; i++) begin
      reply_byte_s = (send_cnt_q == SCNT_W'(HDR_BYTES + PAD_BYTES + 1 + i))
                     ? stat_q[8*i +: 8] : reply_byte_s;
    end
  end

  // Output next values: reply byte only in SEND, busy follows next state, saturating drops.
  always_comb begin
    if (state_q == ST_SEND) begin
      dout_d    = reply_byte_s;
      dout_en_d = 1'b1;
    end else begin
      dout_d    = 8'h00;
      dout_en_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.con_dout    = dout_q;
  assign bus.con_dout_en = dout_en_q;
  assign resp_busy       = busy_q;
  assign drop_cnt        = drop_q;

endmodule
